// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the forwarding scoreboard:
//   - default parameter values for fwd_scoreboard,
//   - SEL_RF, the forward-select code meaning "read the register file",
//   - slot_t, the record tracked for each post-EX pipeline slot,
//   - slot_age(), the per-edge ageing applied as a record moves one slot older.
// slot_t is sized for the widest legal configuration (register address up to
// REG_W_MAX bits, latency up to 7 slots); narrower configurations zero-extend
// into it so every field bit stays meaningful.
// -----------------------------------------------------------------------------
package fwd_pkg;

   localparam int DEF_DEPTH = 2;
   localparam int DEF_NSRC  = 2;
   localparam int DEF_RW    = 5;
   localparam int DEF_CNT_W = 16;

   // Forward select value for "no bypass, use register-file data".
   localparam int SEL_RF    = 0;

   // Widest register address and remaining-latency field carried by a slot.
   localparam int REG_W_MAX = 16;
   localparam int REM_W     = 3;

   typedef struct packed {
      logic                 valid;  // slot holds a real instruction
      logic                 wen;    // instruction writes a register
      logic [REG_W_MAX-1:0] wreg;   // destination register, zero-extended
      logic [REM_W-1:0]     rem;    // slots still to go before forwardable
   } slot_t;

   // One slot older: remaining latency counts down and stops at zero.
   function automatic slot_t slot_age(input slot_t s);
      slot_t r;
      r = s;
      if (s.rem != {REM_W{1'b0}}) begin
         r.rem = s.rem - {{(REM_W-1){1'b0}}, 1'b1};
      end else begin
         r.rem = {REM_W{1'b0}};
      end
      return r;
   endfunction

endpackage

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Per-source priority matcher. Compares one EX source register against every
// in-flight slot and picks the youngest (lowest-index) slot that writes it.
// Ports:
//   slots   in   DEPTH x slot_t   current slot records (slot0 = youngest)
//   src     in   REG_W_MAX        source register, zero-extended
//   used    in   1                operand is actually read
//   sel     out  SW               0 = register file, k+1 = slot k
//   pending out  1                youngest writer exists but is not ready yet
// Register 0 and unused operands never match, so they never forward or stall.
// -----------------------------------------------------------------------------
module fwd_match
   import fwd_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int SW    = $clog2(DEF_DEPTH + 1)
)(
   input  slot_t [DEPTH-1:0]     slots,
   input  logic  [REG_W_MAX-1:0] src,
   input  logic                  used,
   output logic  [SW-1:0]        sel,
   output logic                  pending
);

   logic [DEPTH-1:0] hit_s;
   logic [SW-1:0]    sel_s;
   logic             pend_s;

   // Per-slot hit: live writer of this exact non-zero register.
   always_comb begin
      hit_s = {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         hit_s[k] = used
                  & (src != {REG_W_MAX{1'b0}})
                  & slots[k].valid
                  & slots[k].wen
                  & (slots[k].wreg == src);
      end
   end

   // Priority resolve: scanning oldest to youngest lets the youngest hit
   // overwrite any older one, so the youngest writer decides the outcome.
   always_comb begin
      sel_s  = SW'(SEL_RF);
      pend_s = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (hit_s[k]) begin
            if (slots[k].rem == {REM_W{1'b0}}) begin
               sel_s  = SW'(k + 1);
               pend_s = 1'b0;
            end else begin
               sel_s  = SW'(SEL_RF);
               pend_s = 1'b1;
            end
         end else begin
            sel_s  = sel_s;
            pend_s = pend_s;
         end
      end
   end

   assign sel     = sel_s;
   assign pending = pend_s;

endmodule

// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
// Forwarding / hazard scoreboard for an in-order pipeline. Tracks the
// destination of each instruction in the DEPTH post-EX slots (slot0 = EX/MEM,
// slot1 = MEM/WB, ...) and, for every EX source operand, selects a bypass slot
// or requests a stall when the producing result is not yet available.
// Ports:
//   clk          in   1         rising-edge clock
//   rst_n        in   1         asynchronous active-low reset
//   ex_valid     in   1         EX holds a real instruction
//   ex_wen       in   1         EX instruction writes a register
//   ex_wreg      in   RW        EX destination register
//   ex_lat       in   SW        slots before the result is forwardable
//   ex_src       in   NSRC*RW   source registers, operand i at [i*RW +: RW]
//   ex_src_used  in   NSRC      per-source "operand is read"
//   flush        in   1         kill the EX instruction this cycle
//   stall_o      out  1         hold IF/ID/EX and insert a bubble
//   fwd_sel      out  NSRC*SW   per-source select: 0 = RF, k+1 = slot k
//   stall_cnt    out  CNT_W     saturating count of stall cycles
// stall_o and fwd_sel are combinational from slot state and EX inputs so the
// EX operand muxes see them in the same cycle. RW may be up to REG_W_MAX.
// -----------------------------------------------------------------------------
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter  int DEPTH = DEF_DEPTH,
   parameter  int NSRC  = DEF_NSRC,
   parameter  int RW    = DEF_RW,
   parameter  int CNT_W = DEF_CNT_W,
   localparam int SW    = $clog2(DEPTH + 1)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ex_valid,
   input  logic                 ex_wen,
   input  logic [RW-1:0]        ex_wreg,
   input  logic [SW-1:0]        ex_lat,
   input  logic [NSRC*RW-1:0]   ex_src,
   input  logic [NSRC-1:0]      ex_src_used,
   input  logic                 flush,
   output logic                 stall_o,
   output logic [NSRC*SW-1:0]   fwd_sel,
   output logic [CNT_W-1:0]     stall_cnt
);

   slot_t [DEPTH-1:0] slot_r;
   slot_t             slot0_nxt_s;
   logic  [SW-1:0]    lat_clip_s;
   logic  [NSRC-1:0]  pend_s;
   logic              stall_s;
   logic  [CNT_W-1:0] cnt_r;

   // Latency beyond the last slot cannot be waited out inside the scoreboard,
   // so it is clipped to DEPTH-1 (ready by the time it reaches the last slot).
   always_comb begin
      if (ex_lat > SW'(DEPTH - 1)) begin
         lat_clip_s = SW'(DEPTH - 1);
      end else begin
         lat_clip_s = ex_lat;
      end
   end

   // Per-source matchers; stall_o is never fed back into them.
   for (genvar i = 0; i < NSRC; i++) begin : g_src
      logic [REG_W_MAX-1:0] src_ext_s;
      assign src_ext_s = REG_W_MAX'(ex_src[i*RW +: RW]);

      fwd_match #(
         .DEPTH (DEPTH),
         .SW    (SW)
      ) u_match (
         .slots   (slot_r),
         .src     (src_ext_s),
         .used    (ex_src_used[i]),
         .sel     (fwd_sel[i*SW +: SW]),
         .pending (pend_s[i])
      );
   end

   assign stall_s = ex_valid & ~flush & (|pend_s);

   // Slot0 candidate: the EX instruction when it advances, otherwise a bubble.
   always_comb begin
      slot0_nxt_s = '0;
      if (ex_valid && !flush && !stall_s) begin
         slot0_nxt_s.valid = 1'b1;
         slot0_nxt_s.wen   = ex_wen;
         slot0_nxt_s.wreg  = REG_W_MAX'(ex_wreg);
         slot0_nxt_s.rem   = REM_W'(lat_clip_s);
      end else begin
         slot0_nxt_s = '0;
      end
   end

   // Slot shift register; the downstream pipeline never stalls, so every
   // record moves one slot older on each edge and the last one retires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_r <= '0;
      end else begin
         slot_r[0] <= slot0_nxt_s;
         for (int k = 1; k < DEPTH; k++) begin
            slot_r[k] <= slot_age(slot_r[k-1]);
         end
      end
   end

   // Stall-cycle counter, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign stall_o   = stall_s;
   assign stall_cnt = cnt_r;

endmodule
